// File: rtl/fifo_32x8.sv
// 8-entry x 32-bit synchronous FIFO with registered read data and
// Moore-decoded write/read acknowledge and error flags.
module fifo_32x8 #(
   parameter int DEPTH  = 8,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [DWIDTH-1:0] din,
   output logic [DWIDTH-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              wr_ack,
   output logic              wr_err,
   output logic              rd_ack,
   output logic              rd_err,
   output logic [3:0]        data_count
);

   localparam int PTR_W = 3;

   typedef enum logic [2:0] {
      INIT    = 3'b000,
      NO_OP   = 3'b001,
      WRITE   = 3'b010,
      WR_ERR  = 3'b011,
      READ    = 3'b100,
      RD_ERR  = 3'b101,
      RD_WR   = 3'b110,
      ILLEGAL = 3'b111
   } state_t;

   state_t            state_reg, state_next;
   logic [DWIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  head_reg, tail_reg;
   logic [3:0]        count_reg;
   logic [DWIDTH-1:0] dout_reg;
   logic              wr_acc_reg;
   logic              rd_accept, wr_accept;

   // A read frees a slot on the same edge, so a full FIFO still accepts a write.
   assign rd_accept = rd_en && (count_reg != 4'd0);
   assign wr_accept = wr_en && ((count_reg < 4'(DEPTH)) || rd_accept);

   // Storage carries no reset so it maps onto plain RAM/registers.
   always_ff @(posedge clk) begin
      if (reset_n && wr_accept)
         mem[tail_reg] <= din;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_reg   <= '0;
         tail_reg   <= '0;
         count_reg  <= 4'd0;
         dout_reg   <= '0;
         wr_acc_reg <= 1'b0;
         state_reg  <= INIT;
      end else begin
         state_reg  <= state_next;
         wr_acc_reg <= wr_accept;
         if (wr_accept)
            tail_reg <= tail_reg + 3'd1;
         if (rd_accept) begin
            dout_reg <= mem[head_reg];
            head_reg <= head_reg + 3'd1;
         end
         case ({wr_accept, rd_accept})
            2'b10:   count_reg <= count_reg + 4'd1;
            2'b01:   count_reg <= count_reg - 4'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_comb begin
      state_next = NO_OP;
      wr_ack     = 1'b0;
      wr_err     = 1'b0;
      rd_ack     = 1'b0;
      rd_err     = 1'b0;

      if (state_reg == ILLEGAL)
         state_next = NO_OP;
      else if (rd_en && !rd_accept)
         state_next = RD_ERR;
      else if (wr_en && !wr_accept)
         state_next = WR_ERR;
      else if (wr_accept && rd_accept)
         state_next = RD_WR;
      else if (wr_accept)
         state_next = WRITE;
      else if (rd_accept)
         state_next = READ;
      else
         state_next = NO_OP;

      // RD_ERR alone cannot tell whether the paired write went through.
      case (state_reg)
         WRITE:   wr_ack = 1'b1;
         WR_ERR:  wr_err = 1'b1;
         READ:    rd_ack = 1'b1;
         RD_WR: begin
            wr_ack = 1'b1;
            rd_ack = 1'b1;
         end
         RD_ERR: begin
            rd_err = 1'b1;
            wr_ack = wr_acc_reg;
         end
         default: ;
      endcase
   end

   assign dout       = dout_reg;
   assign data_count = count_reg;
   assign full       = (count_reg == 4'(DEPTH));
   assign empty      = (count_reg == 4'd0);

endmodule

// File: tb/tb_fifo_32x8.sv
// Bench for fifo_32x8: directed scenarios followed by random traffic,
// every output compared against a queue-based reference model.
module tb_fifo_32x8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] din;
    logic [31:0] dout;
    logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
    logic [3:0]  data_count;

    fifo_32x8 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .din        (din),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .data_count (data_count)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus the expected registered outputs.
    logic [31:0] model_q[$];
    logic [31:0] exp_dout;
    logic        exp_wr_ack, exp_wr_err, exp_rd_ack, exp_rd_err;
    logic [2:0]  exp_state;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          step_no  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
            n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [2:0] st;
        st = dut.state_reg;
        chk("data_count", 32'(data_count), 32'(model_q.size()));
        chk("full",       32'(full),       32'(model_q.size() == 8));
        chk("empty",      32'(empty),      32'(model_q.size() == 0));
        chk("dout",       dout,            exp_dout);
        chk("wr_ack",     32'(wr_ack),     32'(exp_wr_ack));
        chk("wr_err",     32'(wr_err),     32'(exp_wr_err));
        chk("rd_ack",     32'(rd_ack),     32'(exp_rd_ack));
        chk("rd_err",     32'(rd_err),     32'(exp_rd_err));
        chk("state",      32'(st),         32'(exp_state));
    endtask

    task automatic do_reset(input logic wr, input logic rd);
        step_no++;
        reset_n = 1'b0;
        wr_en   = wr;
        rd_en   = rd;
        din     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        model_q.delete();
        exp_dout   = 32'h0;
        exp_wr_ack = 1'b0;
        exp_wr_err = 1'b0;
        exp_rd_ack = 1'b0;
        exp_rd_err = 1'b0;
        exp_state  = 3'd0;
        $display("step %0d reset wr=%0b rd=%0b count=%0d", step_no, wr, rd, data_count);
        check_all();
    endtask

    task automatic step(input logic wr, input logic rd, input logic [31:0] d);
        bit rd_ok, wr_ok;
        step_no++;
        rd_ok = rd && (model_q.size() > 0);
        wr_ok = wr && ((model_q.size() < 8) || rd_ok);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (rd_ok)
            exp_dout = model_q.pop_front();
        if (wr_ok)
            model_q.push_back(d);
        exp_wr_ack = wr_ok;
        exp_wr_err = wr && !wr_ok;
        exp_rd_ack = rd_ok;
        exp_rd_err = rd && !rd_ok;
        if (rd && !rd_ok)        exp_state = 3'b101;
        else if (wr && !wr_ok)   exp_state = 3'b011;
        else if (wr_ok && rd_ok) exp_state = 3'b110;
        else if (wr_ok)          exp_state = 3'b010;
        else if (rd_ok)          exp_state = 3'b100;
        else                     exp_state = 3'b001;
        $display("step %0d wr=%0b rd=%0b din=%08h dout=%08h count=%0d", step_no, wr, rd, d, dout,
                 data_count);
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout step=%0d", step_no);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset_n = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = 32'h0;
        #1;

        // Reset state
        do_reset(1'b0, 1'b0);

        // Fill 1..8 then one write too many
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'(i));
        step(1'b1, 1'b0, 32'h99);

        // Drain 8 then one read too many (dout holds 8)
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h0);

        // Pointer wrap: 5 in/out then 6 in/out
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h100 + 32'(i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h200 + 32'(i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h0);

        // Simultaneous access at count 3, then empty, then full
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h300 + 32'(i));
        step(1'b1, 1'b1, 32'h3AA);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b1, 32'h4AA);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h500 + 32'(i));
        step(1'b1, 1'b1, 32'h5AA);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h0);

        // Reset at count 5 with requests asserted, then a read must fail
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h600 + 32'(i));
        do_reset(1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h0);

        // Operand pairing: 3 and 4 out on consecutive cycles
        step(1'b1, 1'b0, 32'h3);
        step(1'b1, 1'b0, 32'h4);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0)
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_32x8.md
FIFO_32X8 -- requirements
Module: fifo_32x8

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning number of 32-bit entries, with pointer width fixed at 3 bits.
REQ-002 The block SHALL have parameter DWIDTH, default 32, meaning width of one entry.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write request for the current cycle.
REQ-006 The block SHALL have port rd_en, input, 1 bit: read request for the current cycle, driven by the consumer's fifo_re.
REQ-007 The block SHALL have port din, input, 32 bits: write data, sampled with wr_en.
REQ-008 The block SHALL have port dout, output, 32 bits: registered read data, the consumer's din.
REQ-009 The block SHALL have port full, output, 1 bit: asserted combinationally from data_count==8.
REQ-010 The block SHALL have port empty, output, 1 bit: asserted combinationally from data_count==0.
REQ-011 The block SHALL have ports wr_ack and wr_err, outputs, 1 bit each: previous-cycle write accepted or rejected.
REQ-012 The block SHALL have ports rd_ack and rd_err, outputs, 1 bit each: previous-cycle read accepted or rejected.
REQ-013 The block SHALL have port data_count, output, 4 bits: current occupancy, range 0..8, the consumer's fifo_data_count.

Function
REQ-014 Storage SHALL be 8x32 registers with 3-bit head (read) and tail (write) pointers; each pointer SHALL increment by 1 per accepted operation and wrap 7->0.
REQ-015 A write SHALL be accepted when wr_en=1 and (data_count<8, or a read is accepted in the same cycle); mem[tail]<=din and tail increments on that edge.
REQ-016 A read SHALL be accepted when rd_en=1 and data_count>0.
REQ-017 On an accepted read, dout<=mem[head] and head increments on that edge, so data is valid the cycle after rd_en (1-cycle latency).
REQ-018 dout SHALL hold its last value when no read is accepted, including on rd_err.
REQ-019 data_count SHALL update as +1 (write only), -1 (read only), or unchanged (both or neither accepted).
REQ-020 Simultaneous wr_en and rd_en when empty: only the write SHALL be accepted and rd_err raised; no write-to-read bypass.
REQ-021 Simultaneous wr_en and rd_en when full: both SHALL be accepted; data_count stays 8 and the write goes to the slot being vacated.
REQ-022 The block SHALL have a 3-bit state register with states INIT=000, NO_OP=001, WRITE=010, WR_ERR=011, READ=100, RD_ERR=101, RD_WR=110, recording the operation outcome of the last edge.
REQ-023 The next state SHALL be selected as: neither request -> NO_OP; write accepted only -> WRITE; read accepted only -> READ; both accepted -> RD_WR.
REQ-024 A rejected request SHALL select the next state as: write rejected, no read -> WR_ERR; read rejected (any write) -> RD_ERR.
REQ-025 Acknowledge outputs SHALL be decoded from state only (Moore): wr_ack=1 in WRITE or RD_WR or (RD_ERR with write accepted).
REQ-026 Error and read-acknowledge outputs SHALL be decoded from state: wr_err=1 in WR_ERR; rd_ack=1 in READ or RD_WR; rd_err=1 in RD_ERR.
REQ-027 A write-accepted flag SHALL be registered to disambiguate wr_ack in the RD_ERR state.
REQ-028 Code 111 SHALL be unreachable; if entered, the next edge SHALL go to NO_OP with all acks and errors 0.

Reset
REQ-029 When reset_n=0 at a rising edge, the block SHALL set state=INIT, head=0, tail=0, data_count=0, dout=0 and all acks and errors to 0, with full=0 and empty=1.
REQ-030 Reset SHALL override any simultaneous wr_en or rd_en, and memory contents need not be cleared.
REQ-031 A reset asserted mid-stream SHALL discard all stored entries.

Verification
REQ-032 Fill test: after reset, write 1..8 on 8 consecutive cycles -> data_count 1..8, full=1 after the 8th, wr_ack=1 each following cycle; a 9th write -> wr_err=1, data_count=8.
REQ-033 Drain test: from full, hold rd_en for 8 cycles -> dout=1..8 one cycle after each rd_en, empty=1 after the last; a 9th read -> rd_err=1 and dout stays 8.
REQ-034 Wrap test: write 5, read 5, write 6, read 6 -> read order matches write order across pointer wrap 7->0, data_count returns to 0.
REQ-035 Simultaneous-access test: at count 3, assert wr_en+rd_en -> rd_ack=1, wr_ack=1, count stays 3; when empty -> rd_err=1, wr_ack=1, count=1; when full -> both acks, count=8.
REQ-036 Reset-mid-operation test: at count 5, pull reset_n low for one edge -> data_count=0, empty=1, dout=0, state=INIT; the next read -> rd_err=1.
REQ-037 Adder-pairing test: load 0x00000003 and 0x00000004, then pulse rd_en on two consecutive cycles -> dout=3 then 4 on the following cycles, data_count=0.
